// File: rtl/itcm_loader_if.sv
// Byte-stream input channel plus ITCM write port and boot status of the ITCM loader.
// master = byte source / observer side, slave = the loader itself.
interface itcm_loader_if #(
  parameter int ITCM_AW = 15
);
  // Valid/ready: a byte transfers on every clk edge where s_valid && s_ready.
  // The source keeps s_data stable while s_valid is high and not yet accepted.
  // Idle gaps of any length are legal.
  logic                 s_valid;
  logic                 s_ready;
  logic [7:0]           s_data;
  logic                 itcm_we;
  logic [ITCM_AW-3:0]   itcm_addr;
  logic [31:0]          itcm_wdata;
  logic                 core_hold;
  logic                 load_done;
  logic                 load_err;

  modport master (
    output s_valid, s_data,
    input  s_ready, itcm_we, itcm_addr, itcm_wdata, core_hold, load_done, load_err
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, itcm_we, itcm_addr, itcm_wdata, core_hold, load_done, load_err
  );
endinterface

// File: rtl/itcm_loader.sv
// Boot loader: parses an A5/LEN/DATA/CSUM byte frame, writes 32-bit words into the ITCM
// and releases the core from reset only once the whole image and its checksum are good.
module itcm_loader #(
  parameter int ITCM_AW = 15
) (
  input  logic             clk,
  input  logic             rst,
  itcm_loader_if.slave     bus,
  output logic [2:0]       dbg_state_o
);
  localparam int          WAW   = ITCM_AW - 2;
  localparam logic [31:0] CAP   = 32'd1 << WAW;
  localparam logic [7:0]  MAGIC = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN0 = 3'd1,
    S_LEN1 = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       len_lo_q, len_lo_d;
  logic [15:0]      len_q, len_d;
  logic [7:0]       csum_q, csum_d;
  logic [WAW-1:0]   word_idx_q, word_idx_d;
  logic [1:0]       lane_q, lane_d;
  logic [23:0]      shift_q, shift_d;
  logic             s_ready_q, s_ready_d;
  logic             we_q, we_d;
  logic [WAW-1:0]   addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             hold_q, hold_d;
  logic             accept;
  logic [15:0]      n_w;
  logic             last_word;

  assign accept    = bus.s_valid && s_ready_q;
  assign n_w       = {bus.s_data, len_lo_q};
  // Compared at 32 bits so a full-capacity image cannot alias through index wrap.
  assign last_word = (32'(word_idx_q) == (32'(len_q) - 32'd1));

  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    len_d      = len_q;
    csum_d     = csum_q;
    word_idx_d = word_idx_q;
    lane_d     = lane_q;
    shift_d    = shift_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (accept && bus.s_data == MAGIC) begin
          state_d = S_LEN0;
          csum_d  = 8'd0;
        end
      end
      S_LEN0: begin
        if (accept) begin
          len_lo_d = bus.s_data;
          csum_d   = csum_q + bus.s_data;
          state_d  = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          len_d      = n_w;
          csum_d     = csum_q + bus.s_data;
          word_idx_d = '0;
          lane_d     = 2'd0;
          if (32'(n_w) > CAP)   state_d = S_ERR;
          else if (n_w == 16'd0) state_d = S_CSUM;
          else                   state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          csum_d = csum_q + bus.s_data;
          if (lane_q == 2'd3) begin
            we_d       = 1'b1;
            addr_d     = word_idx_q;
            wdata_d    = {bus.s_data, shift_q};
            word_idx_d = word_idx_q + {{(WAW-1){1'b0}}, 1'b1};
            lane_d     = 2'd0;
            if (last_word) state_d = S_CSUM;
          end else begin
            case (lane_q)
              2'd0:    shift_d[7:0]   = bus.s_data;
              2'd1:    shift_d[15:8]  = bus.s_data;
              default: shift_d[23:16] = bus.s_data;
            endcase
            lane_d = lane_q + 2'd1;
          end
        end
      end
      S_CSUM: begin
        if (accept) state_d = (bus.s_data == csum_q) ? S_DONE : S_ERR;
      end
      default: state_d = state_q;
    endcase

    // Status outputs follow the next state so they update on the deciding edge.
    s_ready_d = (state_d != S_DONE) && (state_d != S_ERR);
    done_d    = (state_d == S_DONE);
    err_d     = (state_d == S_ERR);
    hold_d    = (state_d != S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_lo_q   <= 8'd0;
      len_q      <= 16'd0;
      csum_q     <= 8'd0;
      word_idx_q <= '0;
      lane_q     <= 2'd0;
      shift_q    <= 24'd0;
      s_ready_q  <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      hold_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      len_q      <= len_d;
      csum_q     <= csum_d;
      word_idx_q <= word_idx_d;
      lane_q     <= lane_d;
      shift_q    <= shift_d;
      s_ready_q  <= s_ready_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
      hold_q     <= hold_d;
    end
  end

  assign bus.s_ready    = s_ready_q;
  assign bus.itcm_we    = we_q;
  assign bus.itcm_addr  = addr_q;
  assign bus.itcm_wdata = wdata_q;
  assign bus.core_hold  = hold_q;
  assign bus.load_done  = done_q;
  assign bus.load_err   = err_q;
  assign dbg_state_o    = state_q;
endmodule
